mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-ported byte-addressable data/instruction memory.
- Port 0 (IF): instruction fetch, read-only.
- Port 1 (DM): data-memory stage, read or write.
- Grants one requester per transaction, drives the memory's address/data_in/mem_write/mem_read, absorbs the memory's 1-cycle registered read latency, and returns registered read data with an ack pulse.
- Sits between pipeline stages and memory. Memory reset stays on memory's own reset.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory (the environment).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        output if_ack, if_rdata, dm_ack, dm_rdata,
               mem_address, mem_data_in, mem_write, mem_read
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
               mem_address, mem_data_in, mem_write, mem_read
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (IF read-only, DM read/write) arbiter and sequencer for a single-ported memory.
// Optional macro DM_FIXED_PRIORITY_EN: DM always wins ties; default is round-robin.
//
// state | meaning
// IDLE  | sample requests, grant one, latch its transaction
// ISSUE | one mem_read or mem_write strobe from latched values
// WAIT  | memory read latency; read data captured on exit
// RESP  | ack pulse to owner, transfer counted, last_grant updated
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic [15:0]       xfer_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_valid;
    logic              grant_port;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              owner;
    logic              lat_we;
    logic              last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        grant_we    = 1'b0;
        grant_addr  = bus.if_addr;
        grant_wdata = bus.dm_wdata;
        // port index 0 = IF, 1 = DM
        if (bus.if_req && bus.dm_req) begin
`ifdef DM_FIXED_PRIORITY_EN
            grant_port = 1'b1;
`else
            grant_port = ~last_grant;
`endif
        end else begin
            grant_port = bus.dm_req;
        end
        if (grant_port) begin
            grant_addr = bus.dm_addr;
            grant_we   = bus.dm_we;
        end
        case (state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant_valid = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and acks are registered one state early so they line up with ISSUE/RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner           <= 1'b0;
            lat_we          <= 1'b0;
            last_grant      <= 1'b0;
            busy            <= 1'b0;
            xfer_cnt        <= 16'h0000;
            bus.if_ack      <= 1'b0;
            bus.dm_ack      <= 1'b0;
            bus.if_rdata    <= '0;
            bus.dm_rdata    <= '0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.mem_write   <= 1'b0;
            bus.mem_read    <= 1'b0;
        end else begin
            busy          <= (state_nxt != IDLE);
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner           <= grant_port;
                        lat_we          <= grant_we;
                        bus.mem_address <= grant_addr;
                        if (grant_port) begin
                            bus.mem_data_in <= grant_wdata;
                        end
                        bus.mem_read    <= ~grant_we;
                        bus.mem_write   <= grant_we;
                    end
                end
                WAIT: begin
                    if (!lat_we) begin
                        if (owner) begin
                            bus.dm_rdata <= bus.mem_data_out;
                        end else begin
                            bus.if_rdata <= bus.mem_data_out;
                        end
                    end
                    if (owner) begin
                        bus.dm_ack <= 1'b1;
                    end else begin
                        bus.if_ack <= 1'b1;
                    end
                end
                RESP: begin
                    xfer_cnt   <= xfer_cnt + 16'd1;
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed memory model with registered read,
// word-level reference model, directed and randomized transactions.
module tb_mem_port_arbiter;
    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] xfer_cnt;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory environment: little-endian 16-bit words, one-cycle registered read
    logic [7:0] mem_bytes [0:65535];
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem_bytes[bus.mem_address]         = bus.mem_data_in[7:0];
            mem_bytes[bus.mem_address + 16'd1] = bus.mem_data_in[15:8];
        end
        if (bus.mem_read) begin
            bus.mem_data_out <= {mem_bytes[bus.mem_address + 16'd1], mem_bytes[bus.mem_address]};
        end
    end

    // reference model state
    logic [15:0] model_mem [int];
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_dm_rdata;
    logic [15:0] exp_cnt;
    bit          exp_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) chk("strobe_overlap", 32'(bus.mem_read & bus.mem_write), 32'h0);

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 16'h0000;
    endfunction

    function automatic bit pick(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef DM_FIXED_PRIORITY_EN
            return 1'b1;
`else
            return !exp_last;
`endif
        end
        return dr;
    endfunction

    task automatic model_reset();
        exp_cnt      = 16'h0;
        exp_last     = 1'b0;
        exp_if_rdata = 16'h0;
        exp_dm_rdata = 16'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_cnt"},   32'(xfer_cnt), 32'h0);
        chk({tag, "_strb"},  32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk({tag, "_ack"},   32'({bus.if_ack, bus.dm_ack}), 32'h0);
        chk({tag, "_rdata"}, 32'({bus.if_rdata, bus.dm_rdata}), 32'h0);
        chk({tag, "_bus"},   32'({bus.mem_address, bus.mem_data_in}), 32'h0);
    endtask

    // Called at the negedge of the IDLE cycle in which the request is visible;
    // returns at the negedge of the following IDLE cycle.
    task automatic expect_txn(input bit port, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input bit single);
        @(negedge clk);
        chk("issue_rd",   32'(bus.mem_read), 32'(!we));
        chk("issue_wr",   32'(bus.mem_write), 32'(we));
        chk("issue_addr", 32'(bus.mem_address), 32'(addr));
        if (we) chk("issue_wdata", 32'(bus.mem_data_in), 32'(wdata));
        chk("issue_busy", 32'(busy), 32'h1);
        chk("issue_ack",  32'({bus.if_ack, bus.dm_ack}), 32'h0);
        if (single) begin
            bus.if_addr  = 16'($urandom);
            bus.dm_addr  = 16'($urandom);
            bus.dm_wdata = 16'($urandom);
            bus.dm_we    = 1'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("wait_strb", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk("wait_addr", 32'(bus.mem_address), 32'(addr));
        chk("wait_ack",  32'({bus.if_ack, bus.dm_ack}), 32'h0);
        @(negedge clk);
        if (we)        model_mem[int'(addr)] = wdata;
        else if (port) exp_dm_rdata = model_rd(addr);
        else           exp_if_rdata = model_rd(addr);
        chk("resp_if_ack",   32'(bus.if_ack), 32'(!port));
        chk("resp_dm_ack",   32'(bus.dm_ack), 32'(port));
        chk("resp_if_rdata", 32'(bus.if_rdata), 32'(exp_if_rdata));
        chk("resp_dm_rdata", 32'(bus.dm_rdata), 32'(exp_dm_rdata));
        chk("resp_strb",     32'({bus.mem_read, bus.mem_write}), 32'h0);
        exp_last = port;
        exp_cnt  = exp_cnt + 16'd1;
        if (single) begin
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_ack",  32'({bus.if_ack, bus.dm_ack}), 32'h0);
        chk("idle_cnt",  32'(xfer_cnt), 32'(exp_cnt));
    endtask

    task automatic single_txn(input bit port, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata);
        if (port) begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = we;
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        expect_txn(port, port & we, addr, wdata, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          g;
        bit          p;
        bit          w;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem_bytes[i] = 8'h00;
        mem_bytes[0] = 8'h11; mem_bytes[1] = 8'h22;
        mem_bytes[2] = 8'h33; mem_bytes[3] = 8'h44;
        model_mem[0] = 16'h2211;
        model_mem[2] = 16'h4433;
        model_reset();
        bus.if_req = 1'b0; bus.if_addr = 16'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
        reset = 1'b1;
        #2 reset = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // IF read of preloaded word
        single_txn(1'b0, 1'b0, 16'h0000, 16'h0);
        // DM write then read back; IF rdata must survive
        single_txn(1'b1, 1'b1, 16'h00A0, 16'hBEEF);
        single_txn(1'b1, 1'b0, 16'h00A0, 16'h0);

        // randomized single-requester traffic
        for (int i = 0; i < 24; i++) begin
            p = 1'($urandom_range(1, 0));
            w = p ? 1'($urandom_range(1, 0)) : 1'b0;
            a = 16'(2 * $urandom_range(31, 8));
            single_txn(p, w, a, 16'($urandom));
        end

        // reset during WAIT of an IF read
        bus.if_req = 1'b1; bus.if_addr = 16'h0000;
        @(negedge clk);
        chk("mid_issue_rd", 32'(bus.mem_read), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_noack", 32'(bus.if_ack), 32'h0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mid_rel_busy", 32'(busy), 32'h0);
        single_txn(1'b0, 1'b0, 16'h0002, 16'h0);

        // both requests held through a reset, then continuously
        bus.if_req = 1'b1; bus.if_addr = 16'h0000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0002;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("held_rst");
        @(negedge clk);
        chk("held_rst_strb", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("held_rel_strb", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        for (int i = 0; i < 5; i++) begin
            g = pick(1'b1, 1'b1);
            expect_txn(g, 1'b0, g ? 16'h0002 : 16'h0000, 16'h0, 1'b0);
        end
        bus.dm_req = 1'b0;
        g = pick(1'b1, 1'b0);
        expect_txn(g, 1'b0, 16'h0000, 16'h0, 1'b0);
        bus.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("end_busy", 32'(busy), 32'h0);
        chk("end_strb", 32'({bus.mem_read, bus.mem_write}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
